// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage RISC-V pipeline: EX forwarding,
// load-use stalls, branch flushes and multi-cycle M-op sequencing with a watchdog.
module pipeline_ctrl #(
   parameter int MD_TIMEOUT = 64,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 id_valid,
   input  logic [4:0]           id_rs1_addr,
   input  logic [4:0]           id_rs2_addr,
   input  logic                 id_ex_valid,
   input  logic [4:0]           id_ex_rs1_addr,
   input  logic [4:0]           id_ex_rs2_addr,
   input  logic [4:0]           id_ex_rd_addr,
   input  logic                 id_ex_mem_read,
   input  logic                 id_ex_muldiv,
   input  logic [4:0]           ex_mem_rd_addr,
   input  logic                 ex_mem_reg_write,
   input  logic [4:0]           mem_wb_rd_addr,
   input  logic                 mem_wb_reg_write,
   input  logic                 branch_taken,
   input  logic                 muldiv_done,
   output logic [1:0]           forward_a,
   output logic [1:0]           forward_b,
   output logic                 pc_stall,
   output logic                 if_id_stall,
   output logic                 id_ex_stall,
   output logic                 if_id_flush,
   output logic                 id_ex_flush,
   output logic                 ex_mem_bubble,
   output logic                 muldiv_start,
   output logic                 muldiv_timeout,
   output logic [CNT_WIDTH-1:0] stall_count
);

   localparam int WD_W = $clog2(MD_TIMEOUT);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(MD_TIMEOUT - 1);

   typedef enum logic {RUN, MD_BUSY} state_t;

   state_t          state;
   logic [WD_W-1:0] wd_cnt;
   logic            ex_mem_hit_a, ex_mem_hit_b, mem_wb_hit_a, mem_wb_hit_b;
   logic            load_use, md_in_ex, wd_expired;

   // x0 is hardwired to zero, so it is never a forwarding source
   assign ex_mem_hit_a = ex_mem_reg_write && (ex_mem_rd_addr != 5'd0) && (ex_mem_rd_addr == id_ex_rs1_addr);
   assign ex_mem_hit_b = ex_mem_reg_write && (ex_mem_rd_addr != 5'd0) && (ex_mem_rd_addr == id_ex_rs2_addr);
   assign mem_wb_hit_a = mem_wb_reg_write && (mem_wb_rd_addr != 5'd0) && (mem_wb_rd_addr == id_ex_rs1_addr);
   assign mem_wb_hit_b = mem_wb_reg_write && (mem_wb_rd_addr != 5'd0) && (mem_wb_rd_addr == id_ex_rs2_addr);

   assign forward_a = ex_mem_hit_a ? 2'b10 : (mem_wb_hit_a ? 2'b01 : 2'b00);
   assign forward_b = ex_mem_hit_b ? 2'b10 : (mem_wb_hit_b ? 2'b01 : 2'b00);

   assign load_use = id_ex_valid && id_ex_mem_read && id_valid && (id_ex_rd_addr != 5'd0) &&
                     ((id_ex_rd_addr == id_rs1_addr) || (id_ex_rd_addr == id_rs2_addr));
   assign md_in_ex   = id_ex_valid && id_ex_muldiv;
   assign wd_expired = (wd_cnt == WD_LAST);

   always_comb begin
      pc_stall      = 1'b0;
      if_id_stall   = 1'b0;
      id_ex_stall   = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      ex_mem_bubble = 1'b0;
      muldiv_start  = 1'b0;
      case (state)
         RUN: begin
            if (md_in_ex) begin
               // start is suppressed while reset is held; stalls still follow the inputs
               muldiv_start  = reset;
               pc_stall      = 1'b1;
               if_id_stall   = 1'b1;
               id_ex_stall   = 1'b1;
               ex_mem_bubble = 1'b1;
            end else if (branch_taken) begin
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
            end else if (load_use) begin
               pc_stall    = 1'b1;
               if_id_stall = 1'b1;
               id_ex_flush = 1'b1;
            end
         end
         MD_BUSY: begin
            if (!muldiv_done) begin
               ex_mem_bubble = 1'b1;
               if (!wd_expired) begin
                  pc_stall    = 1'b1;
                  if_id_stall = 1'b1;
                  id_ex_stall = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= RUN;
         wd_cnt         <= '0;
         muldiv_timeout <= 1'b0;
         stall_count    <= '0;
      end else begin
         if (pc_stall && (stall_count != '1))
            stall_count <= stall_count + CNT_WIDTH'(1);
         case (state)
            RUN: begin
               if (md_in_ex) begin
                  wd_cnt <= '0;
                  state  <= MD_BUSY;
               end
            end
            MD_BUSY: begin
               // a done pulse on the expiry cycle still counts as a normal completion
               if (muldiv_done) begin
                  state <= RUN;
               end else if (wd_expired) begin
                  muldiv_timeout <= 1'b1;
                  state          <= RUN;
               end else begin
                  wd_cnt <= wd_cnt + WD_W'(1);
               end
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed scenarios plus random traffic, each
// cycle's expected outputs come from a behavioural model and are checked by a monitor.
module tb_pipeline_ctrl;

   localparam int TB_TIMEOUT = 8;
   localparam int TB_CNT     = 6;
   localparam int CNT_MAX    = (1 << TB_CNT) - 1;

   typedef struct packed {
      logic       rst_n;
      logic       id_valid;
      logic [4:0] id_rs1;
      logic [4:0] id_rs2;
      logic       id_ex_valid;
      logic [4:0] ex_rs1;
      logic [4:0] ex_rs2;
      logic [4:0] ex_rd;
      logic       mem_read;
      logic       muldiv;
      logic [4:0] exm_rd;
      logic       exm_w;
      logic [4:0] wb_rd;
      logic       wb_w;
      logic       branch;
      logic       done;
   } stim_t;

   typedef struct packed {
      logic [1:0]        fa;
      logic [1:0]        fb;
      logic              pc_stall;
      logic              if_id_stall;
      logic              id_ex_stall;
      logic              if_id_flush;
      logic              id_ex_flush;
      logic              bubble;
      logic              start;
      logic              timeout;
      logic [TB_CNT-1:0] cnt;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              id_valid, id_ex_valid, id_ex_mem_read, id_ex_muldiv;
   logic [4:0]        id_rs1_addr, id_rs2_addr, id_ex_rs1_addr, id_ex_rs2_addr, id_ex_rd_addr;
   logic [4:0]        ex_mem_rd_addr, mem_wb_rd_addr;
   logic              ex_mem_reg_write, mem_wb_reg_write, branch_taken, muldiv_done;
   logic [1:0]        forward_a, forward_b;
   logic              pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush;
   logic              ex_mem_bubble, muldiv_start, muldiv_timeout;
   logic [TB_CNT-1:0] stall_count;

   exp_t exp_q[$];
   int   n_compared   = 0;
   int   n_mismatched = 0;

   // behavioural model state: is an M op outstanding, which busy cycle we are in
   bit   md_busy     = 1'b0;
   int   md_cycle    = 0;
   bit   to_flag     = 1'b0;
   int   stall_total = 0;

   pipeline_ctrl #(.MD_TIMEOUT(TB_TIMEOUT), .CNT_WIDTH(TB_CNT)) dut (
      .clk(clk), .reset(reset),
      .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_ex_valid(id_ex_valid), .id_ex_rs1_addr(id_ex_rs1_addr), .id_ex_rs2_addr(id_ex_rs2_addr),
      .id_ex_rd_addr(id_ex_rd_addr), .id_ex_mem_read(id_ex_mem_read), .id_ex_muldiv(id_ex_muldiv),
      .ex_mem_rd_addr(ex_mem_rd_addr), .ex_mem_reg_write(ex_mem_reg_write),
      .mem_wb_rd_addr(mem_wb_rd_addr), .mem_wb_reg_write(mem_wb_reg_write),
      .branch_taken(branch_taken), .muldiv_done(muldiv_done),
      .forward_a(forward_a), .forward_b(forward_b),
      .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
      .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_bubble(ex_mem_bubble),
      .muldiv_start(muldiv_start), .muldiv_timeout(muldiv_timeout), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input stim_t s);
      if (s.exm_w && s.exm_rd != 5'd0 && s.exm_rd == rs) return 2'b10;
      if (s.wb_w && s.wb_rd != 5'd0 && s.wb_rd == rs) return 2'b01;
      return 2'b00;
   endfunction

   function automatic exp_t compute_expected(input stim_t s);
      exp_t e;
      bit   busy, lu;
      e    = '0;
      e.fa = fwd_sel(s.ex_rs1, s);
      e.fb = fwd_sel(s.ex_rs2, s);
      busy = s.rst_n && md_busy;
      lu   = s.id_ex_valid && s.mem_read && s.id_valid && s.ex_rd != 5'd0 &&
             (s.ex_rd == s.id_rs1 || s.ex_rd == s.id_rs2);
      if (!busy) begin
         if (s.id_ex_valid && s.muldiv) begin
            e.start       = s.rst_n;
            e.pc_stall    = 1'b1;
            e.if_id_stall = 1'b1;
            e.id_ex_stall = 1'b1;
            e.bubble      = 1'b1;
         end else if (s.branch) begin
            e.if_id_flush = 1'b1;
            e.id_ex_flush = 1'b1;
         end else if (lu) begin
            e.pc_stall    = 1'b1;
            e.if_id_stall = 1'b1;
            e.id_ex_flush = 1'b1;
         end
      end else if (!s.done) begin
         e.bubble = 1'b1;
         if (md_cycle != TB_TIMEOUT) begin
            e.pc_stall    = 1'b1;
            e.if_id_stall = 1'b1;
            e.id_ex_stall = 1'b1;
         end
      end
      e.timeout = s.rst_n && to_flag;
      e.cnt     = s.rst_n ? TB_CNT'((stall_total > CNT_MAX) ? CNT_MAX : stall_total) : '0;
      return e;
   endfunction

   task automatic update_model(input stim_t s, input exp_t e);
      if (!s.rst_n) begin
         md_busy     = 1'b0;
         md_cycle    = 0;
         to_flag     = 1'b0;
         stall_total = 0;
      end else begin
         if (e.pc_stall) stall_total++;
         if (!md_busy) begin
            if (s.id_ex_valid && s.muldiv) begin
               md_busy  = 1'b1;
               md_cycle = 1;
            end
         end else if (s.done) begin
            md_busy = 1'b0;
         end else if (md_cycle == TB_TIMEOUT) begin
            md_busy = 1'b0;
            to_flag = 1'b1;
         end else begin
            md_cycle++;
         end
      end
   endtask

   // called just after a rising edge; returns just after the next one
   task automatic applyStimulus(input stim_t s);
      exp_t e;
      reset            = s.rst_n;
      id_valid         = s.id_valid;
      id_rs1_addr      = s.id_rs1;
      id_rs2_addr      = s.id_rs2;
      id_ex_valid      = s.id_ex_valid;
      id_ex_rs1_addr   = s.ex_rs1;
      id_ex_rs2_addr   = s.ex_rs2;
      id_ex_rd_addr    = s.ex_rd;
      id_ex_mem_read   = s.mem_read;
      id_ex_muldiv     = s.muldiv;
      ex_mem_rd_addr   = s.exm_rd;
      ex_mem_reg_write = s.exm_w;
      mem_wb_rd_addr   = s.wb_rd;
      mem_wb_reg_write = s.wb_w;
      branch_taken     = s.branch;
      muldiv_done      = s.done;
      e = compute_expected(s);
      exp_q.push_back(e);
      @(posedge clk);
      update_model(s, e);
      #1;
   endtask

   task automatic cmp_field(input string name, input logic [15:0] act, input logic [15:0] req);
      n_compared++;
      if (act !== req) begin
         n_mismatched++;
         $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
      end
   endtask

   task automatic checkOutput(input exp_t e);
      cmp_field("forward_a",      16'(forward_a),      16'(e.fa));
      cmp_field("forward_b",      16'(forward_b),      16'(e.fb));
      cmp_field("pc_stall",       16'(pc_stall),       16'(e.pc_stall));
      cmp_field("if_id_stall",    16'(if_id_stall),    16'(e.if_id_stall));
      cmp_field("id_ex_stall",    16'(id_ex_stall),    16'(e.id_ex_stall));
      cmp_field("if_id_flush",    16'(if_id_flush),    16'(e.if_id_flush));
      cmp_field("id_ex_flush",    16'(id_ex_flush),    16'(e.id_ex_flush));
      cmp_field("ex_mem_bubble",  16'(ex_mem_bubble),  16'(e.bubble));
      cmp_field("muldiv_start",   16'(muldiv_start),   16'(e.start));
      cmp_field("muldiv_timeout", 16'(muldiv_timeout), 16'(e.timeout));
      cmp_field("stall_count",    16'(stall_count),    16'(e.cnt));
   endtask

   // monitor: outputs are valid every cycle, sampled on the falling edge
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
      end
   end

   function automatic stim_t idle();
      stim_t s;
      s       = '0;
      s.rst_n = 1'b1;
      return s;
   endfunction

   function automatic stim_t rand_stim();
      stim_t s;
      s.rst_n       = ($urandom_range(0, 39) != 0);
      s.id_valid    = ($urandom_range(0, 3) != 0);
      s.id_rs1      = 5'($urandom_range(0, 7));
      s.id_rs2      = 5'($urandom_range(0, 7));
      s.id_ex_valid = ($urandom_range(0, 4) != 0);
      s.ex_rs1      = 5'($urandom_range(0, 7));
      s.ex_rs2      = 5'($urandom_range(0, 7));
      s.ex_rd       = 5'($urandom_range(0, 7));
      s.mem_read    = ($urandom_range(0, 2) == 0);
      s.muldiv      = ($urandom_range(0, 5) == 0);
      s.exm_rd      = 5'($urandom_range(0, 7));
      s.exm_w       = 1'($urandom_range(0, 1));
      s.wb_rd       = 5'($urandom_range(0, 7));
      s.wb_w        = 1'($urandom_range(0, 1));
      s.branch      = ($urandom_range(0, 5) == 0);
      s.done        = ($urandom_range(0, 7) == 0);
      return s;
   endfunction

   initial begin
      stim_t s, ld, md;
      s     = idle();
      s.rst_n = 1'b0;
      reset = 1'b0;
      {id_valid, id_ex_valid, id_ex_mem_read, id_ex_muldiv} = '0;
      {id_rs1_addr, id_rs2_addr, id_ex_rs1_addr, id_ex_rs2_addr, id_ex_rd_addr} = '0;
      {ex_mem_rd_addr, mem_wb_rd_addr, ex_mem_reg_write, mem_wb_reg_write} = '0;
      {branch_taken, muldiv_done} = '0;
      @(posedge clk);
      #1;
      repeat (2) applyStimulus(s);

      // forwarding priority and x0
      s = idle();
      s.exm_w = 1'b1; s.exm_rd = 5'd5; s.wb_w = 1'b1; s.wb_rd = 5'd5;
      s.ex_rs1 = 5'd5; s.ex_rs2 = 5'd5;
      applyStimulus(s);
      s.exm_rd = 5'd6;
      applyStimulus(s);
      s.exm_rd = 5'd0; s.wb_rd = 5'd0; s.ex_rs1 = 5'd0; s.ex_rs2 = 5'd0;
      applyStimulus(s);

      // load-use, then load-use masked by a taken branch
      ld = idle();
      ld.id_ex_valid = 1'b1; ld.mem_read = 1'b1; ld.ex_rd = 5'd7;
      ld.id_valid = 1'b1; ld.id_rs2 = 5'd7;
      applyStimulus(ld);
      applyStimulus(idle());
      ld.branch = 1'b1;
      applyStimulus(ld);
      applyStimulus(idle());

      // M op completing on the fourth busy cycle
      s = idle(); s.rst_n = 1'b0;
      applyStimulus(s);
      md = idle(); md.id_ex_valid = 1'b1; md.muldiv = 1'b1;
      repeat (4) applyStimulus(md);
      md.done = 1'b1;
      applyStimulus(md);
      repeat (2) applyStimulus(idle());

      // M op that never completes: watchdog abort, sticky flag
      md = idle(); md.id_ex_valid = 1'b1; md.muldiv = 1'b1;
      applyStimulus(md);
      repeat (TB_TIMEOUT + 4) applyStimulus(idle());

      // reset in the middle of a busy period
      applyStimulus(md);
      repeat (2) applyStimulus(idle());
      s = idle(); s.rst_n = 1'b0;
      applyStimulus(s);
      repeat (3) applyStimulus(idle());

      // stall counter saturation
      ld.branch = 1'b0;
      repeat (CNT_MAX + 6) applyStimulus(ld);
      applyStimulus(idle());

      repeat (3000) applyStimulus(rand_stim());

      s = idle(); s.rst_n = 1'b0;
      applyStimulus(s);
      @(negedge clk);
      @(negedge clk);
      if (exp_q.size() != 0) begin
         n_mismatched++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage RISC-V pipeline.
- Drives the EX-stage forwarding selects (forward_a/forward_b), load-use stalls, and branch flushes.
- Sequences multi-cycle M-extension ops in EX through a start/done handshake with a timeout watchdog.
- Sits beside ex_stage; consumes pipeline-register fields and ex_stage's branch_taken.

Parameters:
- MD_TIMEOUT, 64, max cycles in MD_BUSY before abort (≥2).
- CNT_WIDTH, 16, width of saturating stall-cycle counter.

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low reset
- id_valid  in  1  IF/ID holds a valid instruction
- id_rs1_addr  in  5  rs1 of instruction in ID
- id_rs2_addr  in  5  rs2 of instruction in ID
- id_ex_valid  in  1  ID/EX valid
- id_ex_rs1_addr  in  5  rs1 of instruction in EX
- id_ex_rs2_addr  in  5  rs2 of instruction in EX
- id_ex_rd_addr  in  5  rd of instruction in EX
- id_ex_mem_read  in  1  EX instruction is a load
- id_ex_muldiv  in  1  EX instruction is a multi-cycle M op
- ex_mem_rd_addr  in  5  rd in EX/MEM
- ex_mem_reg_write  in  1  EX/MEM writes rd
- mem_wb_rd_addr  in  5  rd in MEM/WB
- mem_wb_reg_write  in  1  MEM/WB writes rd
- branch_taken  in  1  from ex_stage, resolved this cycle
- muldiv_done  in  1  M unit result valid (1-cycle pulse)
- forward_a  out  2  EX operand A select
- forward_b  out  2  EX operand B select
- pc_stall  out  1  hold PC
- if_id_stall  out  1  hold IF/ID
- id_ex_stall  out  1  hold ID/EX
- if_id_flush  out  1  invalidate IF/ID at next edge
- id_ex_flush  out  1  insert bubble into ID/EX at next edge
- ex_mem_bubble  out  1  write invalid into EX/MEM at next edge
- muldiv_start  out  1  one-cycle start pulse to M unit
- muldiv_timeout  out  1  sticky watchdog error flag
- stall_count  out  CNT_WIDTH  saturating count of cycles with pc_stall=1

Behaviour:
- Reset (reset=0, async): state=RUN; watchdog counter=0; stall_count=0; muldiv_timeout=0.
  - muldiv_start=0 during reset.
  - All combinational outputs follow the RUN equations using the current inputs.
- Forwarding (combinational, every state):
  - forward_a=2'b10 if ex_mem_reg_write, ex_mem_rd_addr!=0 and ex_mem_rd_addr==id_ex_rs1_addr.
  - Else forward_a=2'b01 if the same condition holds for mem_wb_reg_write/mem_wb_rd_addr.
  - Else forward_a=2'b00.
  - forward_b uses the same rules against id_ex_rs2_addr.
  - EX/MEM always beats MEM/WB. Register x0 is never forwarded.
- Load-use hazard (lu): id_ex_valid & id_ex_mem_read & id_valid & id_ex_rd_addr!=0 & (id_ex_rd_addr==id_rs1_addr | id_ex_rd_addr==id_rs2_addr).
- FSM states: RUN, MD_BUSY.
- RUN, when id_ex_valid & id_ex_muldiv:
  - muldiv_start=1; pc_stall=if_id_stall=id_ex_stall=ex_mem_bubble=1.
  - Watchdog cleared; next state MD_BUSY.
- RUN, when branch_taken (no muldiv in EX):
  - if_id_flush=1, id_ex_flush=1, no stalls.
  - Overrides lu.
- RUN, when lu (no branch_taken):
  - pc_stall=1, if_id_stall=1, id_ex_flush=1.
  - id_ex_stall=0 and ex_mem_bubble=0, so the load advances.
- RUN, otherwise: all control outputs 0.
- RUN ignores muldiv_done.
- MD_BUSY, while muldiv_done=0:
  - pc_stall=if_id_stall=id_ex_stall=ex_mem_bubble=1; flushes 0.
  - Watchdog increments each cycle.
- MD_BUSY, when muldiv_done=1 (including the first MD_BUSY cycle):
  - All stalls and bubble are 0 that cycle, so the M op advances to EX/MEM at the edge.
  - Next state RUN. The op is not restarted, because ID/EX now holds the next instruction.
- Watchdog: if it reaches MD_TIMEOUT-1 with muldiv_done=0:
  - Set muldiv_timeout (sticky until reset).
  - Release stalls that cycle, with ex_mem_bubble=1 so the M op is dropped.
  - Next state RUN.
- branch_taken and lu are ignored in MD_BUSY. The M op is in EX, so branch_taken cannot be asserted there.
- stall_count increments on each clk edge where pc_stall=1 and saturates at all-ones.
- Reset asserted mid-MD_BUSY: immediate return to RUN; no muldiv_start is issued until a muldiv op is seen in EX again.

Test Plan:
- EX/MEM rd=5 writing, MEM/WB rd=5 writing, id_ex_rs1=5, id_ex_rs2=5 -> forward_a=forward_b=2'b10. Change ex_mem_rd to 6 -> both 2'b01. Set all rd=0 -> 2'b00.
- Load in EX with rd=7, ID rs2=7, id_valid=1 -> one cycle with pc_stall=if_id_stall=id_ex_flush=1 and id_ex_stall=0; stall_count 0->1.
- Same load-use plus branch_taken=1 -> if_id_flush=id_ex_flush=1, pc_stall=0.
- muldiv op in EX -> muldiv_start for exactly 1 cycle; stalls held 3 cycles; done pulsed on 4th MD_BUSY cycle -> stalls drop that cycle, RUN next, no second start; stall_count=4.
- muldiv op with done never asserted, MD_TIMEOUT=8 -> after 8 stalled cycles muldiv_timeout=1, ex_mem_bubble=1 on release, state RUN; flag persists until reset.
- reset low during MD_BUSY (async, mid-cycle) -> muldiv_timeout=0, stall_count=0, stalls drop immediately; after release with no muldiv in EX, no muldiv_start.
